// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory stand-in.
package mem_responder_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int         MEM_RESP_LAT_MAX = 15;
    localparam logic [7:0] LFSR_SEED        = 8'hA5;
    localparam logic [7:0] LFSR_TAPS        = 8'hB8;

    // Right-shifting Galois step: feedback taps are applied when the bit shifted out is 1.
    function automatic logic [7:0] lfsrNext(input logic [7:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port (master) and mem_responder (slave).
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_responder_lfsr.sv
// 8-bit Galois LFSR used to add latency jitter; only built with MEM_RESPONDER_JITTER_EN.
`ifdef MEM_RESPONDER_JITTER_EN
module mem_responder_lfsr
    import mem_responder_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = lfsrNext(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule
`endif

// File: rtl/mem_responder.sv
// Fixed-latency word memory answering the multicycle core's read/write requests.
// Optional latency jitter is enabled by defining MEM_RESPONDER_JITTER_EN.
module mem_responder
    import mem_responder_types::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam int                CNT_W    = $clog2(MEM_RESP_LAT_MAX + 4);
    localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    isWrite_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;
    logic [3:0][7:0]         mem_q [DEPTH];

    logic                    accept;
    logic [CNT_W-1:0]        jitter;
    logic [CNT_W-1:0]        loadVal;
    logic [DEPTH_LOG2-1:0]   rdIdx;
    logic                    readOp;
    logic [3:0]              unusedAddrBits;

    assign unusedAddrBits = {^bus.mem_address[31:DEPTH_LOG2+2], bus.mem_address[1:0], 1'b0};

`ifdef MEM_RESPONDER_JITTER_EN
    logic [7:0] lfsrValue;
    logic [5:0] unusedLfsrBits;

    // The current LFSR value sets this request's jitter; it then steps on the same edge.
    mem_responder_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (accept),
        .value   (lfsrValue)
    );

    assign jitter         = {{(CNT_W-2){1'b0}}, lfsrValue[1:0]};
    assign unusedLfsrBits = lfsrValue[7:2];
`else
    assign jitter = '0;
`endif

    assign loadVal = LAT_LOAD + jitter;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    accept  = 1'b1;
                    cnt_d   = loadVal;
                    state_d = (loadVal == '0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A zero-latency-counter request goes straight from IDLE to RESP, so read live bus fields then.
    always_comb begin
        rdIdx   = (state_q == IDLE) ? bus.mem_address[DEPTH_LOG2+1:2] : idx_q;
        readOp  = (state_q == IDLE) ? !bus.mem_write : !isWrite_q;
        rdata_d = rdata_q;
        if (state_d == RESP && state_q != RESP && readOp) begin
            rdata_d = mem_q[rdIdx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isWrite_q <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else if (accept) begin
            isWrite_q <= bus.mem_write;
            idx_q     <= bus.mem_address[DEPTH_LOG2+1:2];
            wdata_q   <= bus.mem_wdata;
            be_q      <= bus.mem_byte_enable;
        end
    end

    // Writes commit on the edge that ends RESP; a reset in RESP drops them.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && isWrite_q) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be_q[lane]) begin
                    mem_q[idx_q][lane] <= wdata_q[8*lane +: 8];
                end
            end
        end
    end

    assign bus.mem_resp  = (state_q == RESP);
    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: timestamp-based reference model plus directed scenarios.
module tb_mem_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int LATENCY    = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;

    mem_responder_if bus ();
    mem_responder_if bus2 ();

    mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(1)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: memory as an associative array, response time as an absolute cycle stamp.
    logic [31:0] modelMem   [int];
    logic [3:0]  modelKnown [int];
    bit          busy        = 1'b0;
    bit          opWrite     = 1'b0;
    bit          expResp     = 1'b0;
    bit          rdataKnown  = 1'b1;
    bit          readKnown   = 1'b0;
    bit          checkEnable = 1'b0;
    int          respAt      = 0;
    int          cycleNum    = 0;
    int          opIdx       = 0;
    int          modelJit    = 0;
    logic [31:0] expRdata    = '0;
    logic [31:0] readVal     = '0;
    logic [31:0] opWdata     = '0;
    logic [31:0] word        = '0;
    logic [3:0]  opBe        = '0;
    logic [7:0]  refLfsr     = 8'hA5;
    int          latQ [$];

    always @(posedge clk) begin
        if (rst) begin
            busy       = 1'b0;
            expRdata   = '0;
            rdataKnown = 1'b1;
            refLfsr    = 8'hA5;
            latQ.delete();
        end else if (busy && cycleNum == respAt) begin
            if (opWrite) begin
                if (!modelMem.exists(opIdx)) begin
                    modelMem[opIdx]   = '0;
                    modelKnown[opIdx] = 4'h0;
                end
                word = modelMem[opIdx];
                for (int lane = 0; lane < 4; lane++) begin
                    if (opBe[lane]) begin
                        word[8*lane +: 8]       = opWdata[8*lane +: 8];
                        modelKnown[opIdx][lane] = 1'b1;
                    end
                end
                modelMem[opIdx] = word;
            end
            busy = 1'b0;
        end else if (!busy && (bus.mem_read || bus.mem_write)) begin
            busy     = 1'b1;
            opWrite  = bus.mem_write;
            opIdx    = int'(bus.mem_address[DEPTH_LOG2+1:2]);
            opWdata  = bus.mem_wdata;
            opBe     = bus.mem_byte_enable;
            modelJit = 0;
`ifdef MEM_RESPONDER_JITTER_EN
            modelJit = int'(refLfsr[1:0]);
            refLfsr  = refLfsr[0] ? ((refLfsr >> 1) ^ 8'hB8) : (refLfsr >> 1);
`endif
            respAt = cycleNum + LATENCY + modelJit;
            latQ.push_back(LATENCY + modelJit);
            readKnown = modelMem.exists(opIdx) && (modelKnown[opIdx] == 4'hF);
            readVal   = readKnown ? modelMem[opIdx] : '0;
        end
        cycleNum++;
        expResp = busy && (cycleNum == respAt);
        if (expResp && !opWrite) begin
            expRdata   = readVal;
            rdataKnown = readKnown;
        end
    end

    always @(negedge clk) begin
        if (checkEnable && !rst) begin
            checkOutput("mem_resp_vs_model", 32'(bus.mem_resp), 32'(expResp));
            if (rdataKnown) begin
                checkOutput("mem_rdata_vs_model", bus.mem_rdata, expRdata);
            end
        end
    end

    task automatic applyStimulus(input bit doRead, input bit doWrite, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output int lat, output logic [31:0] rdata);
        bit got;
        got   = 1'b0;
        lat   = 0;
        rdata = '0;
        @(posedge clk);
        #1;
        bus.mem_read        = doRead;
        bus.mem_write       = doWrite;
        bus.mem_address     = addr;
        bus.mem_wdata       = wdata;
        bus.mem_byte_enable = be;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mem_resp) begin
                got   = 1'b1;
                rdata = bus.mem_rdata;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        checkOutput("resp_seen", 32'(got), 32'd1);
        if (latQ.size() > 0) begin
            checkOutput("latency_vs_model", 32'(lat), 32'(latQ.pop_front()));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          respCount;
        bit          got;
        bit          seen;
        logic [31:0] rd;
        logic [31:0] addrTable [4];

        addrTable = '{32'h40, 32'h80, 32'h44, 32'h10};

        bus.mem_read  = 1'b0; bus.mem_write  = 1'b0; bus.mem_byte_enable  = '0;
        bus.mem_address = '0; bus.mem_wdata  = '0;
        bus2.mem_read = 1'b0; bus2.mem_write = 1'b0; bus2.mem_byte_enable = '0;
        bus2.mem_address = '0; bus2.mem_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst2 = 1'b0;
        checkEnable = 1'b1;
        @(negedge clk);
        checkOutput("reset_resp", 32'(bus.mem_resp), 32'd0);
        checkOutput("reset_rdata", bus.mem_rdata, 32'h0);
        checkOutput("reset_rdata_dut2", bus2.mem_rdata, 32'h0);

        $display("[TB] Scenario 1: write then read");
        applyStimulus(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, lat, rd);
`ifdef MEM_RESPONDER_JITTER_EN
        checkOutput("s1_first_jitter_latency", 32'(lat), 32'd3);
`else
        checkOutput("s1_write_latency", 32'(lat), 32'd2);
`endif
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd);
        checkOutput("s1_read_data", rd, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        checkOutput("s1_resp_one_cycle", 32'(bus.mem_resp), 32'd0);

        $display("[TB] Scenario 2: byte lanes");
        applyStimulus(1'b0, 1'b1, 32'h80, 32'h11223344, 4'hF, lat, rd);
        applyStimulus(1'b0, 1'b1, 32'h80, 32'hAABBCCDD, 4'h5, lat, rd);
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, lat, rd);
        checkOutput("s2_lane_merge", rd, 32'h11BB33DD);

        $display("[TB] Scenario 3: aliasing and alignment");
        applyStimulus(1'b0, 1'b1, 32'h0000_1004, 32'h12345678, 4'hF, lat, rd);
        applyStimulus(1'b1, 1'b0, 32'h0000_0006, 32'h0, 4'h0, lat, rd);
        checkOutput("s3_alias_read", rd, 32'h12345678);

        $display("[TB] Read+write together, and zero byte enable");
        applyStimulus(1'b1, 1'b1, 32'h44, 32'h55667788, 4'hF, lat, rd);
        checkOutput("both_high_rdata_held", rd, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, lat, rd);
        checkOutput("both_high_write_won", rd, 32'h55667788);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h01020304, 4'h0, lat, rd);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd);
        checkOutput("zero_be_no_change", rd, 32'hDEADBEEF);

        $display("[TB] Scenario 4: back-to-back on LATENCY=1 instance");
        @(posedge clk);
        #1;
        bus2.mem_write = 1'b1; bus2.mem_address = 32'h20;
        bus2.mem_wdata = 32'hCAFEF00D; bus2.mem_byte_enable = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus2.mem_resp) got = 1'b1;
        end
        bus2.mem_write = 1'b0;
        checkOutput("s4_preload_resp", 32'(got), 32'd1);
        checkOutput("s4_rdata_untouched_by_write", bus2.mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        bus2.mem_read = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
`ifndef MEM_RESPONDER_JITTER_EN
            checkOutput($sformatf("s4_resp_cycle%0d", i), 32'(bus2.mem_resp), 32'(i % 2));
`endif
            if (bus2.mem_resp) seen = 1'b1;
            if (seen) checkOutput("s4_rdata_stable", bus2.mem_rdata, 32'hCAFEF00D);
        end
        bus2.mem_read = 1'b0;
        checkOutput("s4_any_resp", 32'(seen), 32'd1);

        $display("[TB] Scenario 5: reset during a write");
        applyStimulus(1'b0, 1'b1, 32'h10, 32'h0, 4'hF, lat, rd);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b1; bus.mem_address = 32'h10;
        bus.mem_wdata = 32'hFFFFFFFF; bus.mem_byte_enable = 4'hF;
        @(posedge clk);
        #1;
        checkOutput("s5_busy_no_resp", 32'(bus.mem_resp), 32'd0);
        rst = 1'b1;
        bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        respCount = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_resp) respCount++;
        end
        checkOutput("s5_no_resp_after_reset", 32'(respCount), 32'd0);
        checkOutput("s5_rdata_reset", bus.mem_rdata, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
        checkOutput("s5_write_abandoned", rd, 32'h0);

        $display("[TB] Scenario 6: 64 reads, latency bounds");
        for (int n = 0; n < 64; n++) begin
            applyStimulus(1'b1, 1'b0, addrTable[n % 4], 32'h0, 4'h0, lat, rd);
`ifdef MEM_RESPONDER_JITTER_EN
            checkOutput("s6_latency_in_2_to_5", 32'(lat >= 2 && lat <= 5), 32'd1);
`else
            checkOutput("s6_latency_fixed", 32'(lat), 32'd2);
`endif
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
